// File: rtl/mcdt_pkg.sv
// Shared constants, FSM state type and packet-length decode for the mcdt formatter.
package mcdt_pkg;

    localparam int CH_NUM     = 3;
    localparam int FIFO_DEPTH = 32;
    localparam int DW         = 32;
    localparam int CHW        = 2;
    localparam int LENW       = 6;
    localparam int CNTW       = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } fmt_state_e;

    // Packet length code to word count.
    function automatic logic [LENW-1:0] len_decode(input logic [1:0] code);
        logic [LENW-1:0] len;
        case (code)
            2'd0:    len = 6'd4;
            2'd1:    len = 6'd8;
            2'd2:    len = 6'd16;
            default: len = 6'd32;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mcdt_fmt_fifo.sv
// Per-channel synchronous FIFO with show-ahead read data and an occupancy count.
module mcdt_fmt_fifo #(
    parameter int DEPTH = 32,
    parameter int DW    = 32
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       push_i,
    input  logic [DW-1:0]              data_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage array; contents need no reset since the pointers qualify them.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mcdt_formatter.sv
// Formatter top: per-channel buffering, round-robin packet selection and
// request/grant packet emission.
//  state | meaning
//  IDLE  | look for an eligible channel, latch chid/length when found
//  REQ   | req held with stable chid/length until grant
//  SEND  | one word per cycle from the latched channel, start on first, end on last
module mcdt_formatter
    import mcdt_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DW-1:0]         fmt_data_i,
    input  logic                  fmt_valid_i,
    input  logic [1:0]            fmt_chid_i,
    input  logic [1:0]            cfg_len_i,
    output logic [CH_NUM*6-1:0]   fmt_margin_o,
    output logic [CH_NUM-1:0]     fmt_ovf_o,
    output logic                  fmt_err_o,
    output logic                  fmt_req_o,
    input  logic                  fmt_grant_i,
    output logic [1:0]            fmt_chid_o,
    output logic [5:0]            fmt_length_o,
    output logic [DW-1:0]         fmt_data_o,
    output logic                  fmt_start_o,
    output logic                  fmt_end_o
);

    fmt_state_e       state_q;
    logic [CHW-1:0]   rr_q;
    logic [CHW-1:0]   chid_q;
    logic [LENW-1:0]  len_q;
    logic [LENW-1:0]  sent_q;
    logic             req_q;
    logic             start_q;
    logic             end_q;
    logic [DW-1:0]    data_q;
    logic [CH_NUM-1:0] ovf_q;
    logic             err_q;

    logic [CH_NUM-1:0] push;
    logic [CH_NUM-1:0] pop;
    logic [CH_NUM-1:0] full;
    logic [CH_NUM-1:0] empty;
    logic [CH_NUM-1:0] elig;
    logic [DW-1:0]     rd_data [CH_NUM];
    logic [CNTW-1:0]   count [CH_NUM];
    logic [LENW-1:0]   len_req;
    logic              pop_sel;
    logic              sel_found;
    logic [CHW-1:0]    sel_ch;

    assign len_req = len_decode(cfg_len_i);
    assign pop_sel = (state_q == REQ && fmt_grant_i) || (state_q == SEND && sent_q != len_q);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        assign push[i] = fmt_valid_i && (fmt_chid_i == 2'(i));
        assign pop[i]  = pop_sel && (chid_q == 2'(i)) && !empty[i];
        assign elig[i] = (count[i] >= len_req);
        // Margin follows the registered count, so it moves the cycle after a push/pop.
        assign fmt_margin_o[i*6 +: 6] = 6'(FIFO_DEPTH) - count[i];

        mcdt_fmt_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_fifo (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .push_i  (push[i]),
            .data_i  (fmt_data_i),
            .pop_i   (pop[i]),
            .data_o  (rd_data[i]),
            .full_o  (full[i]),
            .empty_o (empty[i]),
            .count_o (count[i])
        );
    end

    // Round-robin pick: first eligible channel after the last served one.
    always_comb begin
        logic [2:0] idx_w;
        sel_found = 1'b0;
        sel_ch    = '0;
        idx_w     = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            idx_w = {1'b0, rr_q} + 3'(k);
            if (idx_w >= 3'(CH_NUM)) idx_w = idx_w - 3'(CH_NUM);
            if (!sel_found && elig[idx_w[1:0]]) begin
                sel_found = 1'b1;
                sel_ch    = idx_w[1:0];
            end
        end
    end

    // Sticky overflow and illegal-channel flags.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ovf_q <= '0;
            err_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (push & full);
            if (fmt_valid_i && fmt_chid_i >= 2'(CH_NUM)) err_q <= 1'b1;
        end
    end

    // Packet FSM with registered handshake and data outputs.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            chid_q  <= '0;
            len_q   <= '0;
            sent_q  <= '0;
            req_q   <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    start_q <= 1'b0;
                    end_q   <= 1'b0;
                    if (sel_found) begin
                        chid_q  <= sel_ch;
                        len_q   <= len_req;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // The first word is popped on the grant edge itself.
                    if (fmt_grant_i) begin
                        req_q   <= 1'b0;
                        data_q  <= rd_data[chid_q];
                        start_q <= 1'b1;
                        end_q   <= (len_q == 6'd1);
                        sent_q  <= 6'd1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    start_q <= 1'b0;
                    if (sent_q == len_q) begin
                        end_q   <= 1'b0;
                        rr_q    <= chid_q;
                        state_q <= IDLE;
                    end else begin
                        data_q <= rd_data[chid_q];
                        sent_q <= sent_q + 6'd1;
                        end_q  <= (sent_q + 6'd1 == len_q);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fmt_req_o    = req_q;
    assign fmt_chid_o   = chid_q;
    assign fmt_length_o = len_q;
    assign fmt_data_o   = data_q;
    assign fmt_start_o  = start_q;
    assign fmt_end_o    = end_q;
    assign fmt_ovf_o    = ovf_q;
    assign fmt_err_o    = err_q;

endmodule

// File: tb/tb_mcdt_formatter.sv
// Directed bench for mcdt_formatter: reset, single packet, round robin, overflow,
// concurrent push/pop and illegal channel / mid-packet reset.
module tb_mcdt_formatter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] data_in = '0;
    logic        valid = 1'b0;
    logic [1:0]  chid_in = '0;
    logic [1:0]  cfg_len = '0;
    logic [17:0] margin;
    logic [2:0]  ovf;
    logic        err;
    logic        req;
    logic        grant = 1'b0;
    logic [1:0]  chid_out;
    logic [5:0]  length;
    logic [31:0] data_out;
    logic        start;
    logic        pend;

    int checks = 0;
    int errors = 0;
    bit hold_grant = 1'b0;

    mcdt_formatter dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .fmt_data_i   (data_in),
        .fmt_valid_i  (valid),
        .fmt_chid_i   (chid_in),
        .cfg_len_i    (cfg_len),
        .fmt_margin_o (margin),
        .fmt_ovf_o    (ovf),
        .fmt_err_o    (err),
        .fmt_req_o    (req),
        .fmt_grant_i  (grant),
        .fmt_chid_o   (chid_out),
        .fmt_length_o (length),
        .fmt_data_o   (data_out),
        .fmt_start_o  (start),
        .fmt_end_o    (pend)
    );

    always #5 clk = ~clk;

    task automatic write_word(input logic [1:0] ch, input logic [31:0] d);
        valid   = 1'b1;
        chid_in = ch;
        data_in = d;
        @(negedge clk);
    endtask

    task automatic wait_req(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({req, start, pend, chid_out, length, data_out, ovf, err} !== '0) begin
            errors++;
            $display("FAIL %s_outputs: req=%0b start=%0b end=%0b chid=%0d len=%0d data=%h ovf=%b err=%0b, required all zero",
                     tag, req, start, pend, chid_out, length, data_out, ovf, err);
        end
        checks++;
        if (margin !== {6'd32, 6'd32, 6'd32}) begin
            errors++;
            $display("FAIL %s_margin: got %h required %h", tag, margin, {6'd32, 6'd32, 6'd32});
        end
    endtask

    task automatic recv_pkt(input logic [1:0] ech, input int elen, input logic [31:0] base);
        bit ok;
        wait_req(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pkt_req_timeout: no req for ch%0d, required req=1", ech);
            return;
        end
        checks++;
        if (chid_out !== ech || length !== 6'(elen)) begin
            errors++;
            $display("FAIL pkt_hdr: chid=%0d len=%0d required chid=%0d len=%0d", chid_out, length, ech, elen);
        end
        grant = 1'b1;
        @(negedge clk);
        if (!hold_grant) grant = 1'b0;
        for (int i = 0; i < elen; i++) begin
            checks++;
            if (data_out !== base + 32'(i) || start !== (i == 0) || pend !== (i == elen - 1)) begin
                errors++;
                $display("FAIL pkt_word%0d ch%0d: data=%h start=%0b end=%0b required data=%h start=%0b end=%0b",
                         i, ech, data_out, start, pend, base + 32'(i), (i == 0), (i == elen - 1));
            end
            @(negedge clk);
        end
        checks++;
        if (req !== 1'b0 || pend !== 1'b0) begin
            errors++;
            $display("FAIL pkt_gap: req=%0b end=%0b required 0/0", req, pend);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        rstn = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_single();
        cfg_len = 2'd0;
        for (int i = 0; i < 4; i++) write_word(2'd0, 32'h00C0_0000 + 32'(i));
        valid = 1'b0;
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL single_req_early: req=%0b required 0", req);
        end
        checks++;
        if (margin[5:0] !== 6'd28) begin
            errors++;
            $display("FAIL single_margin_full: got %0d required 28", margin[5:0]);
        end
        @(negedge clk);
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL single_req_latency: req=%0b required 1", req);
        end
        recv_pkt(2'd0, 4, 32'h00C0_0000);
        checks++;
        if (margin[5:0] !== 6'd32) begin
            errors++;
            $display("FAIL single_margin_after: got %0d required 32", margin[5:0]);
        end
    endtask

    task automatic test_round_robin();
        cfg_len    = 2'd1;
        hold_grant = 1'b1;
        grant      = 1'b1;
        fork
            begin
                for (int c = 0; c < 3; c++)
                    for (int i = 0; i < 8; i++) write_word(2'(c), 32'hA000_0000 + 32'(c * 16 + i));
                valid = 1'b0;
            end
            begin
                recv_pkt(2'd0, 8, 32'hA000_0000);
                recv_pkt(2'd1, 8, 32'hA000_0010);
                recv_pkt(2'd2, 8, 32'hA000_0020);
            end
        join
        for (int i = 0; i < 8; i++) write_word(2'd0, 32'hA100_0000 + 32'(i));
        valid = 1'b0;
        recv_pkt(2'd0, 8, 32'hA100_0000);
        hold_grant = 1'b0;
        grant      = 1'b0;
    endtask

    task automatic test_overflow();
        cfg_len = 2'd3;
        for (int i = 0; i < 33; i++) write_word(2'd1, 32'hB000_0000 + 32'(i));
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (margin !== {6'd32, 6'd0, 6'd32}) begin
            errors++;
            $display("FAIL ovf_margin: got %h required %h", margin, {6'd32, 6'd0, 6'd32});
        end
        checks++;
        if (ovf !== 3'b010) begin
            errors++;
            $display("FAIL ovf_flag: got %b required 010", ovf);
        end
        recv_pkt(2'd1, 32, 32'hB000_0000);
        repeat (5) @(negedge clk);
        checks++;
        if (req !== 1'b0 || margin[11:6] !== 6'd32) begin
            errors++;
            $display("FAIL ovf_dropped: req=%0b margin1=%0d required 0/32", req, margin[11:6]);
        end
    endtask

    task automatic test_concurrent();
        bit ok;
        cfg_len = 2'd3;
        for (int i = 0; i < 32; i++) write_word(2'd2, 32'hC000_0000 + 32'(i));
        valid = 1'b0;
        wait_req(20, ok);
        checks++;
        if (!ok || chid_out !== 2'd2 || length !== 6'd32) begin
            errors++;
            $display("FAIL conc_hdr: ok=%0b chid=%0d len=%0d required 1/2/32", ok, chid_out, length);
        end
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0;
        checks++;
        if (data_out !== 32'hC000_0000 || start !== 1'b1 || margin[17:12] !== 6'd1) begin
            errors++;
            $display("FAIL conc_word0: data=%h start=%0b margin2=%0d required C0000000/1/1",
                     data_out, start, margin[17:12]);
        end
        fork
            begin
                for (int j = 0; j < 10; j++) write_word(2'd2, 32'hC000_0020 + 32'(j));
                valid = 1'b0;
            end
            begin
                for (int i = 1; i < 32; i++) begin
                    int exp_m;
                    @(negedge clk);
                    exp_m = i + 1 - ((i < 10) ? i : 10);
                    checks++;
                    if (data_out !== 32'hC000_0000 + 32'(i) || start !== 1'b0 || pend !== (i == 31)
                        || margin[17:12] !== 6'(exp_m)) begin
                        errors++;
                        $display("FAIL conc_word%0d: data=%h start=%0b end=%0b margin2=%0d required data=%h end=%0b margin2=%0d",
                                 i, data_out, start, pend, margin[17:12], 32'hC000_0000 + 32'(i), (i == 31), exp_m);
                    end
                end
            end
        join
        @(negedge clk);
        checks++;
        if (margin[17:12] !== 6'd22 || req !== 1'b0) begin
            errors++;
            $display("FAIL conc_after: margin2=%0d req=%0b required 22/0", margin[17:12], req);
        end
        cfg_len = 2'd1;
        recv_pkt(2'd2, 8, 32'hC000_0020);
        checks++;
        if (margin[17:12] !== 6'd30) begin
            errors++;
            $display("FAIL conc_remaining: margin2=%0d required 30", margin[17:12]);
        end
    endtask

    task automatic test_err_and_reset();
        bit ok;
        cfg_len = 2'd0;
        write_word(2'd3, 32'hDEAD_BEEF);
        valid = 1'b0;
        checks++;
        if (err !== 1'b1 || margin !== {6'd30, 6'd32, 6'd32} || req !== 1'b0 || ovf !== 3'b010) begin
            errors++;
            $display("FAIL err_chid: err=%0b margin=%h req=%0b ovf=%b required 1/%h/0/010",
                     err, margin, req, ovf, {6'd30, 6'd32, 6'd32});
        end
        cfg_len = 2'd1;
        for (int i = 0; i < 8; i++) write_word(2'd0, 32'hE000_0000 + 32'(i));
        valid = 1'b0;
        wait_req(20, ok);
        checks++;
        if (!ok || chid_out !== 2'd0) begin
            errors++;
            $display("FAIL rst_req: ok=%0b chid=%0d required 1/0", ok, chid_out);
        end
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (data_out !== 32'hE000_0004) begin
            errors++;
            $display("FAIL rst_word4: data=%h required E0000004", data_out);
        end
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("midpkt_reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (req !== 1'b0 || pend !== 1'b0 || margin !== {6'd32, 6'd32, 6'd32}) begin
            errors++;
            $display("FAIL rst_discard: req=%0b end=%0b margin=%h required 0/0/all 32", req, pend, margin);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_concurrent();
        test_err_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
